// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Request/response bundle between the control/decode logic and the ALU
// operation sequencer.
//
// Parameters
//   DATA_W : operand/result width
//
// Signals
//   req_valid / req_ready : request handshake (controller -> sequencer)
//   req_op                : 4-bit ALU opcode
//   req_a / req_b         : operands
//   req_acc               : take operand a from the accumulator
//                           (present only with ALU_SEQ_ACC_EN defined)
//   rsp_valid / rsp_ready : response handshake (sequencer -> controller)
//   rsp_result            : captured ALU result
//   rsp_flags             : captured {carry, zero, negative, overflow}
//   rsp_err               : opcode was outside the legal range
//
// Modports
//   master : controller side, issues requests and consumes responses
//   slave  : sequencer side, accepts requests and produces responses
//
// Optional feature macro: ALU_SEQ_ACC_EN
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if #(
  parameter int DATA_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
`ifdef ALU_SEQ_ACC_EN
  logic              req_acc;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [3:0]        rsp_flags;
  logic              rsp_err;

`ifdef ALU_SEQ_ACC_EN
  modport master (
    output req_valid, req_op, req_a, req_b, req_acc, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_acc, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
`endif

endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Initiator side of the combinational ALU. Accepts an operation request,
// drives registered operands/opcode to the ALU, waits SETTLE_CYC cycles for
// the ALU paths to settle, captures result and flags, and returns them on a
// valid/ready response channel.
//
// Parameters
//   DATA_W     : operand/result width, must match the ALU instance
//   SETTLE_CYC : cycles from operand drive to result capture (>= 1)
//   CNT_W      : width of the completed-operation counter
//
// Ports
//   i_clk          : system clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   io_bus         : request/response channel (slave modport)
//   o_op_count     : completed response handshakes, wraps silently
//   o_alu_a/b      : registered operands to the ALU
//   o_alu_sel      : registered opcode to the ALU
//   i_alu_result   : ALU result
//   i_alu_carry    : ALU carry flag
//   i_alu_zero     : ALU zero flag
//   i_alu_negative : ALU negative flag
//   i_alu_overflow : ALU overflow flag
//
// Optional feature macro: ALU_SEQ_ACC_EN
//   When defined, an internal accumulator is loaded with every captured
//   result, and a request with req_acc=1 takes operand a from it.
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int DATA_W     = 16,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  alu_op_sequencer_if.slave io_bus,
  output logic [CNT_W-1:0]  o_op_count,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [3:0]        o_alu_sel,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_carry,
  input  logic              i_alu_zero,
  input  logic              i_alu_negative,
  input  logic              i_alu_overflow
);

  // Highest legal opcode (NOT a); anything above is flagged as an error
  // but still issued to the ALU.
  localparam logic [3:0] OP_LAST = 4'b0101;

  // Settle counter needs at least one bit even when SETTLE_CYC is 1.
  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [SCNT_W-1:0]   r_cnt;
  logic                r_err_pend;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [3:0]          r_alu_sel;
  logic [DATA_W-1:0]   r_rsp_result;
  logic [3:0]          r_rsp_flags;
  logic                r_rsp_err;
  logic [CNT_W-1:0]    r_op_count;

  logic                w_req_ready;
  logic                w_rsp_valid;
  logic                w_req_fire;
  logic                w_rsp_fire;
  logic                w_settle_done;
  logic                w_illegal;
  logic [DATA_W-1:0]   w_operand_a;

`ifdef ALU_SEQ_ACC_EN
  logic [DATA_W-1:0]   r_acc;
`endif

  // Handshake qualifiers derived from the current state.
  assign w_req_fire    = io_bus.req_valid && w_req_ready;
  assign w_rsp_fire    = w_rsp_valid && io_bus.rsp_ready;
  assign w_settle_done = (r_state == SETTLE) && (r_cnt == '0);
  assign w_illegal     = (io_bus.req_op > OP_LAST);

  // Operand a source: the accumulator can stand in for req_a so that
  // chained operations need not round-trip the result through the master.
`ifdef ALU_SEQ_ACC_EN
  assign w_operand_a = io_bus.req_acc ? r_acc : io_bus.req_a;
`else
  assign w_operand_a = io_bus.req_a;
`endif

  // State register. Reset drops any in-flight operation on the floor.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs. Both ready and valid are pure
  // decodes of the registered state, so neither depends combinationally
  // on the opposite side of its channel.
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (io_bus.req_valid) begin
          w_next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_rsp_valid = 1'b1;
        if (io_bus.rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Operand/opcode registers toward the ALU. They hold after capture so the
  // ALU output stays quiet until the next accepted request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_err_pend <= 1'b0;
    end else if (w_req_fire) begin
      r_alu_a    <= w_operand_a;
      r_alu_b    <= io_bus.req_b;
      r_alu_sel  <= io_bus.req_op;
      r_err_pend <= w_illegal;
    end
  end

  // Settle counter: loaded with SETTLE_CYC-1 on acceptance so the capture
  // happens exactly SETTLE_CYC edges after the operands were registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_req_fire) begin
      r_cnt <= SETTLE_LOAD;
    end else if ((r_state == SETTLE) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Response capture. Values are only written at the end of SETTLE, so they
  // stay stable throughout RESP and retain the last result afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
    end else if (w_settle_done) begin
      r_rsp_result <= i_alu_result;
      r_rsp_flags  <= {i_alu_carry, i_alu_zero, i_alu_negative, i_alu_overflow};
      r_rsp_err    <= r_err_pend;
    end
  end

`ifdef ALU_SEQ_ACC_EN
  // Accumulator follows every captured result, including illegal-opcode
  // results (which the ALU reports as zero).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (w_settle_done) begin
      r_acc <= i_alu_result;
    end
  end
`endif

  // Completed-operation counter, counts response handshakes and wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_count <= '0;
    end else if (w_rsp_fire) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign io_bus.req_ready  = w_req_ready;
  assign io_bus.rsp_valid  = w_rsp_valid;
  assign io_bus.rsp_result = r_rsp_result;
  assign io_bus.rsp_flags  = r_rsp_flags;
  assign io_bus.rsp_err    = r_rsp_err;
  assign o_op_count        = r_op_count;
  assign o_alu_a           = r_alu_a;
  assign o_alu_b           = r_alu_b;
  assign o_alu_sel         = r_alu_sel;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Drives two sequencer instances (SETTLE_CYC=1/CNT_W=8 and SETTLE_CYC=4/
// CNT_W=2), each attached to a behavioural 16-bit ALU. Expected responses
// are queued when a request is issued and compared when the response
// handshake completes.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [15:0] result;
    logic [3:0]  flags;
    logic        err;
  } expT;

  logic clk;
  logic rstN1;
  logic rstN4;
  logic useDut4;
  logic reqValid;
  logic [3:0] reqOp;
  logic [15:0] reqA;
  logic [15:0] reqB;
  logic rspReady;
`ifdef ALU_SEQ_ACC_EN
  logic reqAcc;
`endif

  int errorCount;
  int checkCount;
  int expCount1;
  int expCount4;
  logic [15:0] modelAcc;
  logic [15:0] lastResult;
  logic [3:0]  lastFlags;
  logic        lastErr;
  expT scoreboard[$];

  alu_op_sequencer_if #(.DATA_W(16)) if1 ();
  alu_op_sequencer_if #(.DATA_W(16)) if4 ();

  logic [7:0]  opCount1;
  logic [1:0]  opCount4;
  logic [15:0] aluA1, aluB1, aluA4, aluB4;
  logic [3:0]  aluSel1, aluSel4;
  logic [19:0] aluOut1, aluOut4;

  // Behavioural ALU: returns {carry, zero, negative, overflow, result}.
  function automatic logic [19:0] aluModel(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
    logic [16:0] wide;
    logic [15:0] r;
    logic c;
    logic v;
    wide = '0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0000: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[15:0];
        c = wide[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'b0001: begin
        r = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'b0010: r = a & b;
      4'b0011: r = a ^ b;
      4'b0100: r = a | b;
      4'b0101: r = ~a;
      default: r = '0;
    endcase
    return {c, (r == 16'h0000), r[15], v, r};
  endfunction

  assign aluOut1 = aluModel(aluSel1, aluA1, aluB1);
  assign aluOut4 = aluModel(aluSel4, aluA4, aluB4);

  assign if1.req_valid = reqValid && !useDut4;
  assign if4.req_valid = reqValid && useDut4;
  assign if1.req_op    = reqOp;
  assign if4.req_op    = reqOp;
  assign if1.req_a     = reqA;
  assign if4.req_a     = reqA;
  assign if1.req_b     = reqB;
  assign if4.req_b     = reqB;
  assign if1.rsp_ready = rspReady && !useDut4;
  assign if4.rsp_ready = rspReady && useDut4;
`ifdef ALU_SEQ_ACC_EN
  assign if1.req_acc   = reqAcc;
  assign if4.req_acc   = reqAcc;
`endif

  alu_op_sequencer #(.DATA_W(16), .SETTLE_CYC(1), .CNT_W(8)) dut1 (
    .i_clk          (clk),
    .i_rst_n        (rstN1),
    .io_bus         (if1),
    .o_op_count     (opCount1),
    .o_alu_a        (aluA1),
    .o_alu_b        (aluB1),
    .o_alu_sel      (aluSel1),
    .i_alu_result   (aluOut1[15:0]),
    .i_alu_carry    (aluOut1[19]),
    .i_alu_zero     (aluOut1[18]),
    .i_alu_negative (aluOut1[17]),
    .i_alu_overflow (aluOut1[16])
  );

  alu_op_sequencer #(.DATA_W(16), .SETTLE_CYC(4), .CNT_W(2)) dut4 (
    .i_clk          (clk),
    .i_rst_n        (rstN4),
    .io_bus         (if4),
    .o_op_count     (opCount4),
    .o_alu_a        (aluA4),
    .o_alu_b        (aluB4),
    .o_alu_sel      (aluSel4),
    .i_alu_result   (aluOut4[15:0]),
    .i_alu_carry    (aluOut4[19]),
    .i_alu_zero     (aluOut4[18]),
    .i_alu_negative (aluOut4[17]),
    .i_alu_overflow (aluOut4[16])
  );

  // Observation mux: the tasks talk to whichever instance useDut4 selects.
  logic        obsReqReady;
  logic        obsRspValid;
  logic [15:0] obsResult;
  logic [3:0]  obsFlags;
  logic        obsErr;
  logic [7:0]  obsCount;
  logic [15:0] obsAluA;
  logic [15:0] obsAluB;
  logic [3:0]  obsAluSel;

  assign obsReqReady = useDut4 ? if4.req_ready  : if1.req_ready;
  assign obsRspValid = useDut4 ? if4.rsp_valid  : if1.rsp_valid;
  assign obsResult   = useDut4 ? if4.rsp_result : if1.rsp_result;
  assign obsFlags    = useDut4 ? if4.rsp_flags  : if1.rsp_flags;
  assign obsErr      = useDut4 ? if4.rsp_err    : if1.rsp_err;
  assign obsCount    = useDut4 ? {6'b0, opCount4} : opCount1;
  assign obsAluA     = useDut4 ? aluA4   : aluA1;
  assign obsAluB     = useDut4 ? aluB4   : aluB1;
  assign obsAluSel   = useDut4 ? aluSel4 : aluSel1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded wait was missed somewhere.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Issue one request, optionally hold off the response, then complete the
  // response handshake and compare against the queued expectation. With
  // pendNext the next request is presented while this one is in flight.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic acc,
                               input int holdCycles, input logic pendNext,
                               input logic [3:0] nextOp,
                               input logic [15:0] nextA,
                               input logic [15:0] nextB);
    logic [15:0] aEff;
    logic [19:0] m;
    expT e;
    expT got;
    int waitCnt;
    int lat;
    int settleCyc;
    bit accepted;
    settleCyc = useDut4 ? 4 : 1;
    aEff = acc ? modelAcc : a;
    m = aluModel(op, aEff, b);
    e.result = m[15:0];
    e.flags = m[19:16];
    e.err = (op > 4'b0101);
    scoreboard.push_back(e);
    if (!useDut4) modelAcc = m[15:0];

    reqValid = 1'b1;
    reqOp = op;
    reqA = a;
    reqB = b;
`ifdef ALU_SEQ_ACC_EN
    reqAcc = acc;
`endif
    accepted = 1'b0;
    waitCnt = 0;
    while (!accepted && waitCnt < 50) begin
      @(negedge clk);
      if (obsReqReady) accepted = 1'b1;
      else waitCnt++;
    end
    if (!accepted) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      reqValid = 1'b0;
      void'(scoreboard.pop_front());
      return;
    end
    @(posedge clk);
    #1;
    if (pendNext) begin
      reqOp = nextOp;
      reqA = nextA;
      reqB = nextB;
`ifdef ALU_SEQ_ACC_EN
      reqAcc = 1'b0;
`endif
    end else begin
      reqValid = 1'b0;
    end
    checkOutput("aluSel", {28'd0, obsAluSel}, {28'd0, op});
    checkOutput("aluA", {16'd0, obsAluA}, {16'd0, aEff});
    checkOutput("aluB", {16'd0, obsAluB}, {16'd0, b});

    lat = 0;
    while (!obsRspValid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", lat, settleCyc);
    if (!obsRspValid) begin
      void'(scoreboard.pop_front());
      return;
    end

    for (int i = 0; i < holdCycles; i++) begin
      checkOutput("holdValid", {31'd0, obsRspValid}, 32'd1);
      checkOutput("holdResult", {16'd0, obsResult}, {16'd0, e.result});
      checkOutput("holdFlags", {28'd0, obsFlags}, {28'd0, e.flags});
      checkOutput("holdReqReady", {31'd0, obsReqReady}, 32'd0);
      checkOutput("holdAluSel", {28'd0, obsAluSel}, {28'd0, op});
      @(posedge clk);
      #1;
    end

    got = scoreboard.pop_front();
    checkOutput("rspResult", {16'd0, obsResult}, {16'd0, got.result});
    checkOutput("rspFlags", {28'd0, obsFlags}, {28'd0, got.flags});
    checkOutput("rspErr", {31'd0, obsErr}, {31'd0, got.err});
    lastResult = obsResult;
    lastFlags = obsFlags;
    lastErr = obsErr;

    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
    if (useDut4) begin
      expCount4 = (expCount4 + 1) % 4;
      checkOutput("opCount", obsCount, expCount4);
    end else begin
      expCount1 = (expCount1 + 1) % 256;
      checkOutput("opCount", obsCount, expCount1);
    end
    checkOutput("rspDrop", {31'd0, obsRspValid}, 32'd0);
  endtask

  initial begin
    int seen;
    errorCount = 0;
    checkCount = 0;
    expCount1 = 0;
    expCount4 = 0;
    modelAcc = '0;
    useDut4 = 1'b0;
    rspReady = 1'b0;
    reqOp = 4'b0001;
    reqA = 16'h1111;
    reqB = 16'h2222;
`ifdef ALU_SEQ_ACC_EN
    reqAcc = 1'b0;
`endif
    // A request presented during reset must not be taken.
    reqValid = 1'b1;
    rstN1 = 1'b0;
    rstN4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstRspValid1", {31'd0, if1.rsp_valid}, 32'd0);
    checkOutput("rstAluSel1", {28'd0, aluSel1}, 32'd0);
    checkOutput("rstAluA1", {16'd0, aluA1}, 32'd0);
    checkOutput("rstOpCount1", {24'd0, opCount1}, 32'd0);
    checkOutput("rstReqReady1", {31'd0, if1.req_ready}, 32'd1);
    checkOutput("rstResult1", {16'd0, if1.rsp_result}, 32'd0);
    checkOutput("rstRspValid4", {31'd0, if4.rsp_valid}, 32'd0);
    checkOutput("rstAluSel4", {28'd0, aluSel4}, 32'd0);
    checkOutput("rstOpCount4", {30'd0, opCount4}, 32'd0);
    checkOutput("rstReqReady4", {31'd0, if4.req_ready}, 32'd1);
    reqValid = 1'b0;
    @(negedge clk);
    rstN1 = 1'b1;
    rstN4 = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] SETTLE_CYC=1 instance");
    applyStimulus(4'b0000, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 4'd0, 16'd0, 16'd0);
    checkOutput("addOvfResult", {16'd0, lastResult}, 32'h8000);
    checkOutput("addOvfFlags", {28'd0, lastFlags}, 32'b0011);

    applyStimulus(4'b0001, 16'h0005, 16'h0005, 1'b0, 5, 1'b1,
                  4'b0010, 16'hF0F0, 16'h0FF0);
    checkOutput("subZeroResult", {16'd0, lastResult}, 32'h0000);
    checkOutput("subZeroFlags", {28'd0, lastFlags}, 32'b0100);
    applyStimulus(4'b0010, 16'hF0F0, 16'h0FF0, 1'b0, 0, 1'b0, 4'd0, 16'd0, 16'd0);
    checkOutput("andResult", {16'd0, lastResult}, 32'h00F0);

    applyStimulus(4'b1010, 16'h1234, 16'h5678, 1'b0, 1, 1'b0, 4'd0, 16'd0, 16'd0);
    checkOutput("illegalResult", {16'd0, lastResult}, 32'h0000);
    checkOutput("illegalFlags", {28'd0, lastFlags}, 32'b0100);
    checkOutput("illegalErr", {31'd0, lastErr}, 32'd1);

    applyStimulus(4'b0011, 16'hAAAA, 16'h5555, 1'b0, 0, 1'b0, 4'd0, 16'd0, 16'd0);
    applyStimulus(4'b0100, 16'h0F00, 16'h00F0, 1'b0, 0, 1'b0, 4'd0, 16'd0, 16'd0);
    applyStimulus(4'b0101, 16'h00FF, 16'h1234, 1'b0, 0, 1'b0, 4'd0, 16'd0, 16'd0);
    applyStimulus(4'b0000, 16'hFFFF, 16'h0001, 1'b0, 2, 1'b0, 4'd0, 16'd0, 16'd0);
    checkOutput("addCarryFlags", {28'd0, lastFlags}, 32'b1100);
    applyStimulus(4'b0001, 16'h0003, 16'h0005, 1'b0, 0, 1'b0, 4'd0, 16'd0, 16'd0);
    checkOutput("subBorrowFlags", {28'd0, lastFlags}, 32'b1010);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                    1'b0, i % 2, 1'b0, 4'd0, 16'd0, 16'd0);
    end

`ifdef ALU_SEQ_ACC_EN
    $display("[TB] accumulator chain");
    applyStimulus(4'b0000, 16'h0000, 16'h0003, 1'b0, 0, 1'b0, 4'd0, 16'd0, 16'd0);
    checkOutput("accFirst", {16'd0, lastResult}, 32'h0003);
    applyStimulus(4'b0000, 16'hDEAD, 16'h0004, 1'b1, 0, 1'b0, 4'd0, 16'd0, 16'd0);
    checkOutput("accSecond", {16'd0, lastResult}, 32'h0007);
`endif

    $display("[TB] SETTLE_CYC=4 instance");
    useDut4 = 1'b1;
    applyStimulus(4'b0000, 16'h1000, 16'h0234, 1'b0, 1, 1'b0, 4'd0, 16'd0, 16'd0);

    // Reset two cycles into SETTLE: the operation must vanish.
    reqValid = 1'b1;
    reqOp = 4'b0000;
    reqA = 16'h0001;
    reqB = 16'h0002;
    seen = 0;
    while (seen < 50 && !obsReqReady) begin
      @(negedge clk);
      seen++;
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN4 = 1'b0;
    #1;
    checkOutput("midRstValid", {31'd0, obsRspValid}, 32'd0);
    checkOutput("midRstReady", {31'd0, obsReqReady}, 32'd1);
    @(negedge clk);
    rstN4 = 1'b1;
    expCount4 = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (obsRspValid) seen++;
    end
    checkOutput("midRstNoRsp", seen, 0);
    checkOutput("midRstCount", obsCount, 32'd0);
    checkOutput("midRstReqReady", {31'd0, obsReqReady}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0011, 16'(i * 16'h0101), 16'h00FF, 1'b0, 0, 1'b0,
                    4'd0, 16'd0, 16'd0);
    end
    checkOutput("countWrap", obsCount, 32'd0);

    checkOutput("scoreboardEmpty", scoreboard.size(), 0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
